// File: rtl/clock_enable_gen.sv
// Multi-channel fractional clock-enable generator.
// Each channel is a phase-accumulator NCO. The carry out of each add gives a one-cycle
// enable pulse and also flips a divide-by-two toggle clock. A small settle FSM raises
// "locked" a fixed number of cycles after reset or after the last valid rate write.
module clock_enable_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 16,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic              cfg_valid;

  lock_state_t       state;
  logic [CNT_W-1:0]  cnt;

  // Out-of-range channel indices are dropped before they can touch any state
  assign cfg_valid = cfg_we && (32'(cfg_ch) < NUM_CH);

  // Per-channel write select and widened accumulator sum (top bit is the carry)
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = cfg_valid && (32'(cfg_ch) == i);
      sum[i]    = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  // Phase accumulators; a config write on a channel takes priority over its carry
  always_ff @(posedge refclk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        inc[i] <= '0;
        acc[i] <= '0;
      end
      ce_out  <= '0;
      clk_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          inc[i]     <= cfg_inc;
          acc[i]     <= '0;
          clk_out[i] <= 1'b0;
          ce_out[i]  <= 1'b0;
        end else if (ch_en[i]) begin
          acc[i]    <= sum[i][ACC_W-1:0];
          ce_out[i] <= sum[i][ACC_W];
          if (sum[i][ACC_W]) begin
            clk_out[i] <= ~clk_out[i];
          end
        end else begin
          ce_out[i] <= 1'b0;
        end
      end
    end
  end

  // Lock FSM: count settle cycles, restart on any accepted write
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state  <= SETTLE;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (cfg_valid) begin
      state  <= SETTLE;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state  <= LOCKED;
            cnt    <= '0;
            locked <= 1'b1;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            locked <= 1'b0;
          end
        end
        LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          state  <= SETTLE;
          cnt    <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
